bcd_seg_scan: RTL and testbench

//   Downstream stage of the 8-bit binary-to-BCD converter. Consumes its hundreds/tens/units BCD

---
 rtl/bcd_disp_pkg.sv | 20 ++
 rtl/seg7_decode.sv | 23 ++
 rtl/bcd_seg_scan.sv | 84 ++++++++
 tb/tb_bcd_seg_scan.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared scan states and 7-segment patterns for the BCD display path
package bcd_disp_pkg;
    typedef enum logic [1:0] {
        S_GE  = 2'd0,
        S_SHI = 2'd1,
        S_BAI = 2'd2
    } state_t;
    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to {g..a} segments, dash for codes A-F
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: 3-digit multiplexed 7-segment scanner with frame-synchronous update
module bcd_seg_scan
    import bcd_disp_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bai,
    input  logic [3:0] shi,
    input  logic [3:0] ge,
    input  logic       load,
    input  logic       blank_en,
    output logic [6:0] seg,
    output logic [2:0] dig_sel,
    output logic       frame
);
    localparam int CW = $clog2(CLK_DIV);
    logic [CW-1:0] cnt;
    logic          tick, boundary, blank, pend_valid;
    state_t        state, state_nx;
    logic [3:0]    pend_bai, pend_shi, pend_ge, disp_bai, disp_shi, disp_ge, cur;
    logic [6:0]    dec;
    assign tick     = cnt == CW'(CLK_DIV - 1);
    assign boundary = tick && state == S_BAI;
    always_comb begin
        state_nx = state;
        if (tick)
            state_nx = state == S_GE ? S_SHI : state == S_SHI ? S_BAI : S_GE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            state <= S_GE;
        end else begin
            cnt   <= tick ? '0 : cnt + 1'b1;
            state <= state_nx;
        end
    end
    // A load on the boundary cycle lands in pend after the old pend moved to disp
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_bai   <= '0;
            pend_shi   <= '0;
            pend_ge    <= '0;
            pend_valid <= 1'b0;
            disp_bai   <= '0;
            disp_shi   <= '0;
            disp_ge    <= '0;
        end else begin
            if (load) begin
                pend_bai   <= bai;
                pend_shi   <= shi;
                pend_ge    <= ge;
                pend_valid <= 1'b1;
            end else if (boundary) begin
                pend_valid <= 1'b0;
            end
            if (boundary && pend_valid) begin
                disp_bai <= pend_bai;
                disp_shi <= pend_shi;
                disp_ge  <= pend_ge;
            end
        end
    end
    assign cur   = state == S_BAI ? disp_bai : state == S_SHI ? disp_shi : disp_ge;
    assign blank = blank_en && (state == S_BAI ? disp_bai == 4'd0 :
                                state == S_SHI ? (disp_bai == 4'd0 && disp_shi == 4'd0) : 1'b0);
    seg7_decode u_dec (
        .bcd(cur),
        .seg(dec)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg     <= SEG_OFF;
            dig_sel <= 3'b111;
            frame   <= 1'b0;
        end else begin
            seg     <= blank ? SEG_OFF : dec;
            dig_sel <= state == S_BAI ? 3'b011 : state == S_SHI ? 3'b101 : 3'b110;
            frame   <= boundary;
        end
    end
endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb_bcd_seg_scan: directed scenarios plus random loads checked against a cycle-count reference model
module tb_bcd_seg_scan;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] bai = '0, shi = '0, ge = '0;
    logic       load = 1'b0, blank_en = 1'b0;
    logic [6:0] seg;
    logic [2:0] dig_sel;
    logic       frame;
    int         n_chk = 0, n_fail = 0;

    bcd_seg_scan #(.CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .bai(bai), .shi(shi), .ge(ge),
        .load(load), .blank_en(blank_en), .seg(seg), .dig_sel(dig_sel), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    // Reference: edge e (counted from reset) falls in slot ((e-1)/4)%3, every 12th edge closes a frame
    int         e = 0, st = 0;
    logic [3:0] pb = '0, ps = '0, pg = '0, db = '0, ds = '0, dg = '0, dgt = '0;
    logic       pv = 1'b0, blk = 1'b0;
    logic [6:0] ex_seg = '0;
    logic [2:0] ex_dig = 3'b111;
    logic       ex_fr = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e = 0; pv = 0;
            pb = 0; ps = 0; pg = 0; db = 0; ds = 0; dg = 0;
            ex_seg = 0; ex_dig = 3'b111; ex_fr = 0;
        end else begin
            e++;
            st     = ((e - 1) / 4) % 3;
            dgt    = st == 2 ? db : st == 1 ? ds : dg;
            blk    = blank_en && ((st == 2 && db == 0) || (st == 1 && db == 0 && ds == 0));
            ex_seg = blk ? 7'b0 : seg_ref(dgt);
            ex_dig = 3'b111 & ~(3'b001 << st);
            ex_fr  = (e % 12) == 0;
            if (ex_fr && pv) begin
                db = pb; ds = ps; dg = pg; pv = 0;
            end
            if (load) begin
                pb = bai; ps = shi; pg = ge; pv = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_seg", {1'b0, seg}, {1'b0, ex_seg});
            check("model_dig", {5'b0, dig_sel}, {5'b0, ex_dig});
            check("model_frame", {7'b0, frame}, {7'b0, ex_fr});
        end
    end

    task automatic do_load(input logic [3:0] b, input logic [3:0] s, input logic [3:0] g);
        bai = b; shi = s; ge = g; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_frame();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame !== 1'b1 && k < 40);
        check("frame_wait", {7'b0, frame}, 8'd1);
    endtask

    task automatic check_slot(input string tag, input logic [2:0] d, input logic [6:0] s);
        int k = 0;
        while (dig_sel !== d && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_dig"}, {5'b0, dig_sel}, {5'b0, d});
        check({tag, "_seg"}, {1'b0, seg}, {1'b0, s});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #2;
        check("async_rst_seg", {1'b0, seg}, 8'd0);
        check("async_rst_dig", {5'b0, dig_sel}, 8'b111);
        check("async_rst_frame", {7'b0, frame}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("first_tick_dig", {5'b0, dig_sel}, 8'b110);

        do_load(4'd1, 4'd0, 4'd6);
        wait_frame(); wait_frame();
        check_slot("s2_ge", 3'b110, 7'b1111101);
        check_slot("s2_shi", 3'b101, 7'b0111111);
        check_slot("s2_bai", 3'b011, 7'b0000110);

        blank_en = 1'b1;
        do_load(4'd0, 4'd4, 4'd3);
        wait_frame(); wait_frame();
        check_slot("s3_ge", 3'b110, 7'b1001111);
        check_slot("s3_shi", 3'b101, 7'b1100110);
        check_slot("s3_bai", 3'b011, 7'b0000000);

        do_load(4'd0, 4'd0, 4'd3);
        wait_frame(); wait_frame();
        check_slot("s4_ge", 3'b110, 7'b1001111);
        check_slot("s4_shi", 3'b101, 7'b0000000);
        check_slot("s4_bai", 3'b011, 7'b0000000);
        do_load(4'd0, 4'd0, 4'd0);
        wait_frame(); wait_frame();
        check_slot("s4_zero_ge", 3'b110, 7'b0111111);

        do_load(4'd0, 4'd0, 4'hA);
        wait_frame(); wait_frame();
        check_slot("s5_dash_ge", 3'b110, 7'b1000000);
        do_load(4'd0, 4'hF, 4'd1);
        wait_frame(); wait_frame();
        check_slot("s5_ge", 3'b110, 7'b0000110);
        check_slot("s5_dash_shi", 3'b101, 7'b1000000);

        blank_en = 1'b0;
        check_slot("s6_pre_shi", 3'b101, 7'b1000000);
        do_load(4'd2, 4'd5, 4'd5);
        check_slot("s6_mid_bai", 3'b011, 7'b0111111);
        wait_frame();
        check_slot("s6_ge", 3'b110, 7'b1101101);
        check_slot("s6_shi", 3'b101, 7'b1101101);
        check_slot("s6_bai", 3'b011, 7'b1011011);

        wait_frame();
        do_load(4'd1, 4'd2, 4'd3);
        repeat (10) @(negedge clk);
        do_load(4'd4, 4'd5, 4'd6);
        check("s6_coinc_frame", {7'b0, frame}, 8'd1);
        check_slot("s6_old_ge", 3'b110, 7'b1001111);
        wait_frame();
        check_slot("s6_new_ge", 3'b110, 7'b1111101);
        check_slot("s6_new_bai", 3'b011, 7'b1100110);

        repeat (800) begin
            load = ($urandom % 6) == 0;
            bai  = 4'($urandom % 16);
            shi  = 4'($urandom % 4 == 0 ? 0 : $urandom % 16);
            ge   = 4'($urandom % 16);
            if ($urandom % 40 == 0) blank_en = ~blank_en;
            if ($urandom % 4 == 0) bai = 4'd0;
            @(negedge clk);
        end
        load = 1'b0;
        repeat (30) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
